ascon_aead_sequencer: RTL and testbench
=======================================

Name: ascon_aead_sequencer

Overview:
Top-level phase controller for the ASCON-128 AEAD datapath: initialization, associated-data absorption, plaintext/ciphertext processing, finalization and tag release. It drives the state-register control strobes, supplies the round index to the one-round-per-cycle permutation, and handshakes block-by-block with the AD and data loaders. The rate is 8 bytes; lengths are in bytes.

Parameters:
ROUNDS_A, 12, rounds for initialization and finalization permutation (p^a)
ROUNDS_B, 6, rounds for intermediate permutation (p^b)

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
decrypt  in  1  mode, latched at start; forwarded on mode_dec
ad_len  in  5  AD byte count, latched at start
pt_len  in  5  PT/CT byte count, latched at start
abort  in  1  synchronous return to IDLE from any state
ad_valid  in  1  AD loader has a block ready
data_valid  in  1  data loader has a block ready
tag_ready  in  1  consumer accepts tag
busy  out  1  state != IDLE
mode_dec  out  1  latched decrypt
load_init  out  1  load IV||K||N into state
round_en  out  1  apply one permutation round this cycle
round_idx  out  4  round-constant index 0..11
xor_key_lo  out  1  XOR key into last 128 state bits
xor_key_fin  out  1  XOR key into capacity words 1..2
xor_dsep  out  1  XOR domain-separation bit
ad_ready  out  1  absorb AD block (AD_read to loader)
data_ready  out  1  process data block
blk_len  out  4  valid bytes of current block, 0..8
blk_last  out  1  current block is final (padded) block
tag_valid  out  1  tag available
done  out  1  tag_valid & tag_ready

Behaviour:
- Reset (async, nRST=0): state IDLE, all counters 0, all outputs 0. Reset mid-operation discards everything.
- Block counts: nblk_ad = ad_len[4:3]+1 when ad_len!=0, else 0 (AD phase skipped). nblk_pt = pt_len[4:3]+1, always >=1. The padded block is always processed.
- blk_len: 8 for non-last blocks; len[2:0] on the last block (0..7). blk_last=1 on the last block only.
- States and per-cycle outputs:
  - IDLE: start=1 latches decrypt/ad_len/pt_len -> LOAD.
  - LOAD (1 cycle): load_init=1 -> PERM_A.
  - PERM_A (ROUNDS_A cycles): round_en=1, round_idx 0..11 -> KEY1 (after init) or TAG (after final).
  - KEY1 (1 cycle): xor_key_lo=1 -> AD_WAIT if nblk_ad>0, else DSEP.
  - AD_WAIT: ad_ready=ad_valid. On handshake, blk_len/blk_last valid that cycle and AD is XORed -> PERM_B.
  - PERM_B (ROUNDS_B cycles): round_en=1, round_idx 6..11. Returns to AD_WAIT if AD blocks remain, DSEP after the last AD block, DATA_WAIT during the data phase.
  - DSEP (1 cycle): xor_dsep=1 -> DATA_WAIT.
  - DATA_WAIT: data_ready=data_valid. On handshake, non-last -> PERM_B; last -> FIN_KEY. The last data block gets no p^b.
  - FIN_KEY (1 cycle): xor_key_fin=1 -> PERM_A.
  - TAG: tag_valid=1, held until tag_ready. done=1 in the handshake cycle -> IDLE.
- round_idx is 0 whenever round_en=0.
- start while busy is ignored. Lengths are stable internally once latched.
- abort=1 forces IDLE on the next edge with counters cleared. abort has priority over every transition, including same-cycle handshakes. A handshake coincident with abort is still reported on outputs that cycle.
- ad_valid/data_valid low: the FSM waits indefinitely. There is no timeout.

Decomposition:
- Package ascon_pkg: state_t enum; constants RATE_BYTES=8, ROUNDS_A, ROUNDS_B, ROUND_IDX_B_START=12-ROUNDS_B.
- Sub-module ascon_round_ctr:
  - inputs: clk, nRST, clr, go, is_a.
  - outputs: round_en, round_idx, last_round.
  - loads start index 0 or 6, counts to 11, pulses last_round.
- The FSM, block counters and blk_len logic stay in the top.

Test Plan:
- ad_len=0, pt_len=0, valids/tag_ready held high, start at cycle 0:
  - LOAD at 1; PERM_A idx 0..11 at cycles 2-13; KEY1 at 14; DSEP at 15.
  - Data handshake at 16 with blk_len=0, blk_last=1; FIN_KEY at 17; PERM_A at 18-29.
  - tag_valid and done at 30; IDLE at 31.
- ad_len=19: three AD handshakes, blk_len 8, 8, 3, blk_last only on the third. Each is followed by 6 rounds idx 6..11, then DSEP.
- pt_len=16: data blk_len 8, 8, 0. PERM_B after the first two only; FIN_KEY directly after the third.
- ad_valid low for 5 cycles in AD_WAIT: ad_ready=0 and no round_en throughout. Sequence resumes unchanged once ad_valid rises.
- abort in the 3rd PERM_B cycle: next cycle busy=0, all outputs 0. A subsequent start runs a full clean sequence. start pulses during the run are ignored.
- nRST low mid-PERM_A: outputs 0 immediately (asynchronous), IDLE after release. tag_ready low for 4 cycles in TAG: tag_valid held, done only on acceptance.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared types and constants for the ASCON-128 AEAD phase sequencer.
//   state_t            - sequencer FSM states
//   RATE_BYTES         - bytes absorbed per block
//   ROUNDS_A/ROUNDS_B  - permutation round counts for p^a / p^b
//   ROUND_IDX_B_START  - first round-constant index used by p^b
//   ROUND_IDX_LAST     - final round-constant index of every permutation
package ascon_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_PERM_A,
    S_KEY1,
    S_AD_WAIT,
    S_PERM_B,
    S_DSEP,
    S_DATA_WAIT,
    S_FIN_KEY,
    S_TAG
  } state_t;

  localparam int          RATE_BYTES        = 8;
  localparam int          ROUNDS_A          = 12;
  localparam int          ROUNDS_B          = 6;
  localparam int          ROUND_IDX_B_START = 12 - ROUNDS_B;
  localparam logic [3:0]  ROUND_IDX_LAST    = 4'd11;

  // Number of rate blocks for a byte length. The padded block is always
  // present, except that an empty AD string skips the AD phase entirely.
  function automatic logic [2:0] num_blocks(input logic [4:0] len,
                                            input logic       empty_is_zero);
    if (empty_is_zero && (len == 5'd0)) begin
      return 3'd0;
    end
    return {1'b0, len[4:3]} + 3'd1;
  endfunction

endpackage

// File: rtl/ascon_round_ctr.sv
// ascon_round_ctr
// Round-constant index generator for the one-round-per-cycle permutation.
//   clk, nRST   - clock, async active-low reset
//   clr         - synchronous clear (abort), wins over go
//   go          - start a permutation next cycle
//   is_a        - with go: p^a (index from 12-ROUNDS_A) or p^b (12-ROUNDS_B)
//   round_en    - a round is applied this cycle
//   round_idx   - round-constant index, 0 while idle
//   last_round  - this cycle applies the final round (index 11)
module ascon_round_ctr
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A_P = ROUNDS_A,
  parameter int ROUNDS_B_P = ROUNDS_B
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       clr,
  input  logic       go,
  input  logic       is_a,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       last_round
);

  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A_P);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B_P);

  logic       active_q, active_d;
  logic [3:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      active_q <= 1'b0;
      idx_q    <= 4'd0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    if (clr) begin
      active_d = 1'b0;
      idx_d    = 4'd0;
    end else if (go) begin
      active_d = 1'b1;
      idx_d    = is_a ? START_A : START_B;
    end else if (active_q) begin
      if (idx_q == ROUND_IDX_LAST) begin
        // Park the index at 0 so round_idx reads 0 whenever idle.
        active_d = 1'b0;
        idx_d    = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  assign round_en   = active_q;
  assign round_idx  = idx_q;
  assign last_round = active_q && (idx_q == ROUND_IDX_LAST);

endmodule

// File: rtl/ascon_aead_sequencer.sv
// ascon_aead_sequencer
// Phase controller for the ASCON-128 AEAD datapath.
//   Inputs : clk, nRST (async active-low), start, decrypt, ad_len[4:0],
//            pt_len[4:0], abort, ad_valid, data_valid, tag_ready
//   Outputs: busy, mode_dec, load_init, round_en, round_idx[3:0],
//            xor_key_lo, xor_key_fin, xor_dsep, ad_ready, data_ready,
//            blk_len[3:0], blk_last, tag_valid, done
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// LOAD      | load IV||K||N into the state
// PERM_A    | p^a rounds 0..11 (after init or after finalization key)
// KEY1      | XOR key into the low 128 state bits
// AD_WAIT   | wait for an AD block, absorb on handshake
// PERM_B    | p^b rounds 6..11 between blocks
// DSEP      | XOR domain-separation bit
// DATA_WAIT | wait for a PT/CT block, process on handshake
// FIN_KEY   | XOR key into capacity words 1..2
// TAG       | tag held until accepted
module ascon_aead_sequencer
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = ascon_pkg::ROUNDS_A,
  parameter int ROUNDS_B = ascon_pkg::ROUNDS_B
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic       decrypt,
  input  logic [4:0] ad_len,
  input  logic [4:0] pt_len,
  input  logic       abort,
  input  logic       ad_valid,
  input  logic       data_valid,
  input  logic       tag_ready,
  output logic       busy,
  output logic       mode_dec,
  output logic       load_init,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       xor_key_lo,
  output logic       xor_key_fin,
  output logic       xor_dsep,
  output logic       ad_ready,
  output logic       data_ready,
  output logic [3:0] blk_len,
  output logic       blk_last,
  output logic       tag_valid,
  output logic       done
);

  state_t     state_q, state_d;
  logic       dec_q, dec_d;
  logic [4:0] ad_len_q, ad_len_d;
  logic [4:0] pt_len_q, pt_len_d;
  logic [2:0] ad_cnt_q, ad_cnt_d;
  logic [2:0] pt_cnt_q, pt_cnt_d;
  logic       in_data_q, in_data_d;
  logic       fin_q, fin_d;

  logic [2:0] nblk_ad, nblk_pt;
  logic       ad_last, pt_last;
  logic       last_round, rc_go, rc_is_a;

  assign nblk_ad = num_blocks(ad_len_q, 1'b1);
  assign nblk_pt = num_blocks(pt_len_q, 1'b0);
  assign ad_last = (ad_cnt_q == nblk_ad - 3'd1);
  assign pt_last = (pt_cnt_q == nblk_pt - 3'd1);

  // Permutations start on entry to a PERM state; none is entered twice in a row.
  assign rc_go   = ((state_d == S_PERM_A) || (state_d == S_PERM_B)) && (state_d != state_q);
  assign rc_is_a = (state_d == S_PERM_A);

  ascon_round_ctr #(
    .ROUNDS_A_P (ROUNDS_A),
    .ROUNDS_B_P (ROUNDS_B)
  ) u_round_ctr (
    .clk        (clk),
    .nRST       (nRST),
    .clr        (abort),
    .go         (rc_go),
    .is_a       (rc_is_a),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .last_round (last_round)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      dec_q     <= 1'b0;
      ad_len_q  <= 5'd0;
      pt_len_q  <= 5'd0;
      ad_cnt_q  <= 3'd0;
      pt_cnt_q  <= 3'd0;
      in_data_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      ad_len_q  <= ad_len_d;
      pt_len_q  <= pt_len_d;
      ad_cnt_q  <= ad_cnt_d;
      pt_cnt_q  <= pt_cnt_d;
      in_data_q <= in_data_d;
      fin_q     <= fin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    ad_len_d  = ad_len_q;
    pt_len_d  = pt_len_q;
    ad_cnt_d  = ad_cnt_q;
    pt_cnt_d  = pt_cnt_q;
    in_data_d = in_data_q;
    fin_d     = fin_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dec_d     = decrypt;
          ad_len_d  = ad_len;
          pt_len_d  = pt_len;
          ad_cnt_d  = 3'd0;
          pt_cnt_d  = 3'd0;
          in_data_d = 1'b0;
          fin_d     = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_PERM_A;
      S_PERM_A: if (last_round) state_d = fin_q ? S_TAG : S_KEY1;
      S_KEY1:   state_d = (nblk_ad != 3'd0) ? S_AD_WAIT : S_DSEP;
      S_AD_WAIT: begin
        if (ad_valid) begin
          ad_cnt_d = ad_cnt_q + 3'd1;
          state_d  = S_PERM_B;
        end
      end
      S_PERM_B: begin
        if (last_round) begin
          if (in_data_q)                  state_d = S_DATA_WAIT;
          else if (ad_cnt_q == nblk_ad)   state_d = S_DSEP;
          else                            state_d = S_AD_WAIT;
        end
      end
      S_DSEP: begin
        in_data_d = 1'b1;
        state_d   = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (data_valid) begin
          pt_cnt_d = pt_cnt_q + 3'd1;
          // The final data block goes straight to finalization, no p^b.
          state_d  = pt_last ? S_FIN_KEY : S_PERM_B;
        end
      end
      S_FIN_KEY: begin
        fin_d   = 1'b1;
        state_d = S_PERM_A;
      end
      S_TAG:   if (tag_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      dec_d     = 1'b0;
      ad_len_d  = 5'd0;
      pt_len_d  = 5'd0;
      ad_cnt_d  = 3'd0;
      pt_cnt_d  = 3'd0;
      in_data_d = 1'b0;
      fin_d     = 1'b0;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    mode_dec    = dec_q;
    load_init   = 1'b0;
    xor_key_lo  = 1'b0;
    xor_key_fin = 1'b0;
    xor_dsep    = 1'b0;
    ad_ready    = 1'b0;
    data_ready  = 1'b0;
    blk_len     = 4'd0;
    blk_last    = 1'b0;
    tag_valid   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_LOAD:    load_init   = 1'b1;
      S_KEY1:    xor_key_lo  = 1'b1;
      S_DSEP:    xor_dsep    = 1'b1;
      S_FIN_KEY: xor_key_fin = 1'b1;
      S_AD_WAIT: begin
        ad_ready = ad_valid;
        blk_len  = ad_last ? {1'b0, ad_len_q[2:0]} : 4'(RATE_BYTES);
        blk_last = ad_last;
      end
      S_DATA_WAIT: begin
        data_ready = data_valid;
        blk_len    = pt_last ? {1'b0, pt_len_q[2:0]} : 4'(RATE_BYTES);
        blk_last   = pt_last;
      end
      S_TAG: begin
        tag_valid = 1'b1;
        done      = tag_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
module tb_ascon_aead_sequencer;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0, decrypt = 1'b0, abort = 1'b0;
  logic [4:0] ad_len = '0, pt_len = '0;
  logic       ad_valid = 1'b0, data_valid = 1'b0, tag_ready = 1'b0;
  logic       busy, mode_dec, load_init, round_en, xor_key_lo, xor_key_fin, xor_dsep;
  logic       ad_ready, data_ready, blk_last, tag_valid, done;
  logic [3:0] round_idx, blk_len;

  ascon_aead_sequencer dut (
    .clk(clk), .nRST(nRST), .start(start), .decrypt(decrypt), .ad_len(ad_len),
    .pt_len(pt_len), .abort(abort), .ad_valid(ad_valid), .data_valid(data_valid),
    .tag_ready(tag_ready), .busy(busy), .mode_dec(mode_dec), .load_init(load_init),
    .round_en(round_en), .round_idx(round_idx), .xor_key_lo(xor_key_lo),
    .xor_key_fin(xor_key_fin), .xor_dsep(xor_dsep), .ad_ready(ad_ready),
    .data_ready(data_ready), .blk_len(blk_len), .blk_last(blk_last),
    .tag_valid(tag_valid), .done(done)
  );

  always #5 clk = ~clk;

  wire [19:0] outvec = {busy, mode_dec, load_init, round_en, round_idx, xor_key_lo,
                        xor_key_fin, xor_dsep, ad_ready, data_ready, blk_len, blk_last,
                        tag_valid, done};

  localparam logic [3:0] K_LOAD = 4'd1, K_RND = 4'd2, K_KLO = 4'd3, K_DSEP = 4'd4,
                         K_AD = 4'd5, K_DAT = 4'd6, K_KFIN = 4'd7, K_TAG = 4'd8;

  typedef struct packed {
    logic [3:0]  kind;
    logic [3:0]  val;
    logic        last;
    logic [31:0] cyc;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0, checks = 0;
  int  cyc = 0, base_cyc = 0, push_n = 0;
  bit  strict = 1'b0;
  bit  exp_dec = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [3:0] k, input logic [3:0] v, input logic l);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.last = l;
    e.cyc  = 32'(base_cyc + 1 + push_n);
    exp_q.push_back(e);
    push_n++;
  endfunction

  // Reference: expected event trace of a whole operation from its lengths.
  function automatic void build(input int ad, input int pt);
    int nad, npt;
    bit lst;
    nad = (ad == 0) ? 0 : ad / 8 + 1;
    npt = pt / 8 + 1;
    push(K_LOAD, 4'd0, 1'b0);
    for (int r = 0; r < 12; r++) push(K_RND, 4'(r), 1'b0);
    push(K_KLO, 4'd0, 1'b0);
    for (int i = 0; i < nad; i++) begin
      lst = (i == nad - 1);
      push(K_AD, lst ? 4'(ad % 8) : 4'd8, lst);
      for (int r = 6; r < 12; r++) push(K_RND, 4'(r), 1'b0);
    end
    push(K_DSEP, 4'd0, 1'b0);
    for (int j = 0; j < npt; j++) begin
      lst = (j == npt - 1);
      push(K_DAT, lst ? 4'(pt % 8) : 4'd8, lst);
      if (!lst) for (int r = 6; r < 12; r++) push(K_RND, 4'(r), 1'b0);
    end
    push(K_KFIN, 4'd0, 1'b0);
    for (int r = 0; r < 12; r++) push(K_RND, 4'(r), 1'b0);
    push(K_TAG, 4'd0, 1'b0);
  endfunction

  // Monitor: one observable event per cycle at most, popped from the scoreboard.
  ev_t act_ev, exp_ev;
  int  n_str;
  always @(negedge clk) begin
    if (!round_en) chk("idx_idle", 32'(round_idx), 32'd0);
    chk("done_hs", 32'(done), 32'(tag_valid & tag_ready));
    chk("ad_ready_gate", 32'(ad_ready & ~ad_valid), 32'd0);
    chk("data_ready_gate", 32'(data_ready & ~data_valid), 32'd0);
    if (busy) chk("mode_dec", 32'(mode_dec), 32'(exp_dec));
    n_str = int'(load_init) + int'(round_en) + int'(xor_key_lo) + int'(xor_dsep) +
            int'(ad_ready) + int'(data_ready) + int'(xor_key_fin) + int'(done);
    if (n_str > 1) begin
      chk("one_strobe", 32'(n_str), 32'd1);
    end else if (n_str == 1) begin
      act_ev = '0;
      act_ev.cyc = 32'(cyc);
      if (load_init)        act_ev.kind = K_LOAD;
      else if (round_en)    begin act_ev.kind = K_RND; act_ev.val = round_idx; end
      else if (xor_key_lo)  act_ev.kind = K_KLO;
      else if (xor_dsep)    act_ev.kind = K_DSEP;
      else if (ad_ready)    begin act_ev.kind = K_AD; act_ev.val = blk_len; act_ev.last = blk_last; end
      else if (data_ready)  begin act_ev.kind = K_DAT; act_ev.val = blk_len; act_ev.last = blk_last; end
      else if (xor_key_fin) act_ev.kind = K_KFIN;
      else                  act_ev.kind = K_TAG;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(act_ev.kind), 32'd0);
      end else begin
        exp_ev = exp_q.pop_front();
        chk("ev_kind", 32'(act_ev.kind), 32'(exp_ev.kind));
        chk("ev_val", 32'(act_ev.val), 32'(exp_ev.val));
        chk("ev_last", 32'(act_ev.last), 32'(exp_ev.last));
        if (strict) chk("ev_cycle", act_ev.cyc, exp_ev.cyc);
      end
    end
  end

  task automatic begin_op(input int ad, input int pt, input bit dec, input bit strict_t);
    @(posedge clk); #1;
    ad_len = 5'(ad); pt_len = 5'(pt); decrypt = dec; exp_dec = dec;
    strict = strict_t;
    base_cyc = cyc; push_n = 0;
    build(ad, pt);
    start = 1'b1;
  endtask

  // mode 0: all handshakes immediate, cycle-exact; 1: random valids, start
  // pulses and input churn; 2: AD valid held low after KEY1; 3: tag stall.
  task automatic run_op(input int ad, input int pt, input bit dec, input int mode);
    int budget = 0, hold = 0, tag_wait = 0;
    bit stalled = 1'b0;
    begin_op(ad, pt, dec, mode == 0);
    ad_valid = (mode != 2); data_valid = 1'b1; tag_ready = (mode != 3);
    @(posedge clk); #1;
    start = 1'b0;
    while (exp_q.size() != 0 && budget < 3000) begin
      budget++;
      if (mode == 1) begin
        ad_valid   = ($urandom_range(0, 3) != 0);
        data_valid = ($urandom_range(0, 3) != 0);
        tag_ready  = ($urandom_range(0, 3) != 0);
        start      = busy && ($urandom_range(0, 5) == 0);
        decrypt    = 1'($urandom);
        ad_len     = 5'($urandom_range(0, 31));
        pt_len     = 5'($urandom_range(0, 31));
      end else if (mode == 2) begin
        if (hold > 0) begin
          chk("stall_ad_ready", 32'(ad_ready), 32'd0);
          chk("stall_round_en", 32'(round_en), 32'd0);
          hold--;
          if (hold == 0) ad_valid = 1'b1;
        end else if (xor_key_lo && !stalled) begin
          stalled = 1'b1;
          hold = 6;
        end
      end else if (mode == 3) begin
        if (tag_valid && tag_wait < 5) begin
          chk("tag_stall_done", 32'(done), 32'd0);
          tag_wait++;
          if (tag_wait == 5) tag_ready = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (mode == 3) chk("tag_wait_cycles", 32'(tag_wait), 32'd5);
    chk("idle_after_tag", 32'(busy), 32'd0);
  endtask

  task automatic run_abort(input int ad, input int pt, input bit dec);
    int budget = 0;
    bit seen_key = 1'b0, hit = 1'b0;
    begin_op(ad, pt, dec, 1'b0);
    ad_valid = 1'b1; data_valid = 1'b1; tag_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!hit && budget < 500) begin
      budget++;
      if (xor_key_lo) seen_key = 1'b1;
      if (seen_key && round_en && round_idx == 4'd8) begin
        abort = 1'b1;
        hit = 1'b1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk("abort_reached", 32'(hit), 32'd1);
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outputs", 32'(outvec), 32'd0);
    @(posedge clk); #1;
    chk("abort_stays_idle", 32'(outvec), 32'd0);
  endtask

  task automatic run_reset(input int ad, input int pt);
    int budget = 0;
    begin_op(ad, pt, 1'b1, 1'b0);
    ad_valid = 1'b1; data_valid = 1'b1; tag_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(round_en && round_idx == 4'd5) && budget < 100) begin
      budget++;
      @(posedge clk); #1;
    end
    chk("rst_reached", 32'(round_en && round_idx == 4'd5), 32'd1);
    #1 nRST = 1'b0;
    #1 chk("rst_async_outputs", 32'(outvec), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 nRST = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle_after", 32'(outvec), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 32'(outvec), 32'd0);
    nRST = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(outvec), 32'd0);

    run_op(0, 0, 1'b0, 0);
    run_op(19, 5, 1'b1, 0);
    run_op(3, 16, 1'b0, 0);
    run_op(8, 31, 1'b1, 0);
    run_op(19, 7, 1'b0, 2);
    run_abort(19, 10, 1'b1);
    run_op(8, 9, 1'b0, 0);
    run_reset(5, 5);
    run_op(0, 31, 1'b1, 3);
    for (int k = 0; k < 12; k++)
      run_op($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1);
    run_op(31, 24, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
